// File: rtl/hdlc_flag_tx.sv
// HDLC transmitter: opening/closing flags, zero-bit stuffing, abort on underrun,
// minimum idle gap between frames. One-byte holding register feeds the shifter.
module hdlc_flag_tx #(
  parameter int unsigned ABORT_ONES = 7,
  parameter int unsigned IDLE_MIN   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       w,
  output logic       busy,
  output logic       frame_done,
  output logic       abort
);

  typedef enum logic [2:0] {
    IDLE, OPEN_FLAG, DATA, STUFF, CLOSE_FLAG, ABORT, GAP
  } state_t;

  localparam logic [7:0] FLAG = 8'b0111_1110;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  shifter, shift_n;
  logic        shift_last, last_n;
  logic [2:0]  ones, ones_n;
  logic        hold_valid, hold_last;
  logic [7:0]  hold_data;
  logic        take, byte_end, cur_bit;
  logic        w_n, busy_n, frame_done_n, abort_n;

  assign data_ready = !hold_valid;
  assign cur_bit    = shifter[cnt[2:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shifter    <= '0;
      shift_last <= 1'b0;
      ones       <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      w          <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shifter    <= shift_n;
      shift_last <= last_n;
      ones       <= ones_n;
      w          <= w_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      abort      <= abort_n;
      // take requires a full register, accept an empty one: never both
      if (take) begin
        hold_valid <= 1'b0;
      end else if (data_valid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= data_in;
        hold_last  <= data_last;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_n  = shifter;
    last_n   = shift_last;
    ones_n   = ones;
    take     = 1'b0;
    byte_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_valid) begin
          state_n = OPEN_FLAG;
          cnt_n   = '0;
        end
      end
      OPEN_FLAG: begin
        if (cnt == 4'd7) begin
          state_n = DATA;
          cnt_n   = '0;
          ones_n  = '0;
          take    = 1'b1;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      DATA: begin
        if (cur_bit && ones == 3'd4) begin
          state_n = STUFF;
          ones_n  = '0;
        end else begin
          ones_n = cur_bit ? ones + 3'd1 : '0;
          if (cnt == 4'd7) byte_end = 1'b1;
          else             cnt_n    = cnt + 4'd1;
        end
      end
      STUFF: begin
        // cnt still indexes the bit that completed the run of five
        if (cnt == 4'd7) begin
          byte_end = 1'b1;
        end else begin
          state_n = DATA;
          cnt_n   = cnt + 4'd1;
        end
      end
      CLOSE_FLAG: begin
        if (cnt == 4'd7) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      ABORT: begin
        if (cnt == 4'(ABORT_ONES - 1)) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      GAP: begin
        if (cnt == 4'(IDLE_MIN - 1)) begin
          state_n = hold_valid ? OPEN_FLAG : IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (byte_end) begin
      cnt_n = '0;
      if (shift_last)      state_n = CLOSE_FLAG;
      else if (hold_valid) begin
        state_n = DATA;
        take    = 1'b1;
      end else             state_n = ABORT;
    end

    if (take) begin
      shift_n = hold_data;
      last_n  = hold_last;
    end
  end

  // Outputs are decoded from the next state so that w and the pulses are flops.
  always_comb begin
    w_n          = 1'b1;
    busy_n       = 1'b1;
    frame_done_n = 1'b0;
    abort_n      = 1'b0;
    unique case (state_n)
      OPEN_FLAG:  w_n = FLAG[cnt_n[2:0]];
      DATA:       w_n = shift_n[cnt_n[2:0]];
      STUFF:      w_n = 1'b0;
      CLOSE_FLAG: begin
        w_n          = FLAG[cnt_n[2:0]];
        frame_done_n = (cnt_n == 4'd7);
      end
      ABORT:      abort_n = (cnt_n == 4'(ABORT_ONES - 1));
      default:    busy_n = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_hdlc_flag_tx.sv
// Bench for hdlc_flag_tx: table of frames checked by a bit-stream scoreboard,
// plus directed reset, underrun and back-to-back sequences.
module tb_hdlc_flag_tx;

  localparam int unsigned AO = 7;
  localparam int unsigned IM = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       w;
  logic       busy;
  logic       frame_done;
  logic       abort;

  hdlc_flag_tx #(.ABORT_ONES(AO), .IDLE_MIN(IM)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .w          (w),
    .busy       (busy),
    .frame_done (frame_done),
    .abort      (abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] bits;
    int           len;
    bit           is_abort;
  } exp_t;

  typedef struct {
    int         n;
    logic [7:0] d [4];
    bit         last;
    int         exp_len;
  } vec_t;

  exp_t sbq [$];
  int checks   = 0;
  int failures = 0;

  logic [127:0] cap;
  int cap_len, fd_n, fd_pos, ab_n, ab_pos, gap_cnt, last_gap, rise_cyc;
  bit prev_busy;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference bit stream: flag, software-stuffed payload, then flag or abort ones.
  function automatic exp_t model(input logic [7:0] d [4], input int n, input bit last);
    exp_t e;
    logic [7:0] fl = 8'h7E;
    int ones = 0;
    e.bits = '0;
    e.len  = 0;
    for (int i = 0; i < 8; i++) begin e.bits[e.len] = fl[i]; e.len++; end
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 8; i++) begin
        e.bits[e.len] = d[b][i];
        e.len++;
        if (d[b][i]) begin
          ones++;
          if (ones == 5) begin e.bits[e.len] = 1'b0; e.len++; ones = 0; end
        end else begin
          ones = 0;
        end
      end
    end
    if (last) begin
      for (int i = 0; i < 8; i++) begin e.bits[e.len] = fl[i]; e.len++; end
    end else begin
      for (int i = 0; i < int'(AO); i++) begin e.bits[e.len] = 1'b1; e.len++; end
    end
    e.is_abort = !last;
    return e;
  endfunction

  function automatic vec_t mk(input int n, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input bit last, input int len);
    vec_t v;
    v.n = n; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = 8'h00;
    v.last = last; v.exp_len = len;
    return v;
  endfunction

  task automatic finish_frame();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("unexpected_frame_len", 128'(cap_len), 128'd0);
    end else begin
      e = sbq.pop_front();
      chk("frame_len", 128'(cap_len), 128'(e.len));
      chk("frame_bits", cap, e.bits);
      if (e.is_abort)
        chk("abort_pulse", {fd_n, fd_pos, ab_n, ab_pos}, {32'd0, fd_pos, 32'd1, e.len - 1});
      else
        chk("done_pulse", {fd_n, fd_pos, ab_n, ab_pos}, {32'd1, e.len - 1, 32'd0, ab_pos});
    end
  endtask

  // Monitor: samples on the falling edge, collects each busy window as a frame.
  initial begin
    prev_busy = 0; cap_len = 0; fd_n = 0; ab_n = 0; gap_cnt = 0; last_gap = 0; rise_cyc = 0;
    fd_pos = 0; ab_pos = 0; cap = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        cap_len = 0; fd_n = 0; ab_n = 0; prev_busy = 0; gap_cnt = 0;
      end else if (busy) begin
        if (!prev_busy) begin
          last_gap = gap_cnt; rise_cyc = cyc; cap = '0; cap_len = 0; fd_n = 0; ab_n = 0;
        end
        if (cap_len < 128) cap[cap_len] = w;
        if (frame_done) begin fd_n++; fd_pos = cap_len; end
        if (abort)      begin ab_n++; ab_pos = cap_len; end
        cap_len++;
        prev_busy = 1;
      end else begin
        if (prev_busy) begin finish_frame(); gap_cnt = 0; end
        gap_cnt++;
        chk("idle_w", 128'(w), 128'd1);
        chk("idle_pulses", 128'({frame_done, abort}), 128'd0);
        prev_busy = 0;
      end
    end
  end

  task automatic send(input logic [7:0] d [8], input bit l [8], input int n, output int xf);
    int waited;
    xf = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_valid = 1'b1; data_in = d[i]; data_last = l[i];
      waited = 0;
      while (!data_ready && waited < 400) begin @(negedge clk); waited++; end
      if (waited >= 400) begin tmo("send_ready"); break; end
      @(posedge clk);
      #1;
      if (i == 0) xf = cyc;
    end
    @(negedge clk);
    data_valid = 1'b0; data_last = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((sbq.size() != 0 || busy) && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) tmo("frame_complete");
    repeat (IM + 2) @(negedge clk);
  endtask

  initial begin
    vec_t       tbl [7];
    exp_t       e;
    logic [7:0] dd [8];
    bit         ll [8];
    logic [7:0] md [4];
    int         xf, t;

    data_valid = 1'b0; data_last = 1'b0; data_in = 8'h00;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("reset_w", 128'(w), 128'd1);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_ready", 128'(data_ready), 128'd1);
    chk("reset_pulses", 128'({frame_done, abort}), 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    tbl[0] = mk(1, 8'h00, 8'h00, 8'h00, 1'b1, 24);
    tbl[1] = mk(1, 8'hFF, 8'h00, 8'h00, 1'b1, 25);
    tbl[2] = mk(2, 8'hE0, 8'h03, 8'h00, 1'b1, 33);
    tbl[3] = mk(1, 8'h1F, 8'h00, 8'h00, 1'b0, 24);
    tbl[4] = mk(3, 8'h7E, 8'hFF, 8'h01, 1'b1, 42);
    tbl[5] = mk(1, 8'hF8, 8'h00, 8'h00, 1'b1, 25);
    tbl[6] = mk(2, 8'hAA, 8'h55, 8'h00, 1'b1, 32);

    for (int i = 0; i < 7; i++) begin
      e = model(tbl[i].d, tbl[i].n, tbl[i].last);
      e.len = tbl[i].exp_len;
      sbq.push_back(e);
      for (int j = 0; j < 8; j++) begin
        dd[j] = (j < 4) ? tbl[i].d[j] : 8'h00;
        ll[j] = (j == tbl[i].n - 1) ? tbl[i].last : 1'b0;
      end
      send(dd, ll, tbl[i].n, xf);
      wait_done();
      chk("start_latency", 128'(rise_cyc - xf), 128'd1);
    end

    // Reset while payload bit 3 is on the line, with a transfer attempted under reset.
    dd[0] = 8'hFF; ll[0] = 1'b1;
    send(dd, ll, 1, xf);
    t = 0;
    while (cap_len != 12 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) tmo("reach_payload_bit3");
    #2 reset = 1'b0;
    #1;
    chk("midreset_w", 128'(w), 128'd1);
    chk("midreset_busy", 128'(busy), 128'd0);
    chk("midreset_ready", 128'(data_ready), 128'd1);
    @(negedge clk);
    data_valid = 1'b1; data_in = 8'h55; data_last = 1'b1;
    @(negedge clk);
    data_valid = 1'b0; data_last = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("ignored_xfer_ready", 128'(data_ready), 128'd1);
    chk("ignored_xfer_busy", 128'(busy), 128'd0);
    md[0] = 8'h00; md[1] = 8'h00; md[2] = 8'h00; md[3] = 8'h00;
    sbq.push_back(model(md, 1, 1'b1));
    dd[0] = 8'h00; ll[0] = 1'b1;
    send(dd, ll, 1, xf);
    wait_done();
    chk("post_reset_latency", 128'(rise_cyc - xf), 128'd1);

    // Back-to-back frames with data_valid held high across the boundary.
    md[0] = 8'h12;
    sbq.push_back(model(md, 1, 1'b1));
    md[0] = 8'h34; md[1] = 8'h56;
    sbq.push_back(model(md, 2, 1'b1));
    dd[0] = 8'h12; ll[0] = 1'b1;
    dd[1] = 8'h34; ll[1] = 1'b0;
    dd[2] = 8'h56; ll[2] = 1'b1;
    send(dd, ll, 3, xf);
    wait_done();
    chk("b2b_gap", 128'(last_gap), 128'(IM));

    // Random frames, expectation purely from the reference model.
    for (int r = 0; r < 6; r++) begin
      int n = int'($urandom_range(1, 4));
      for (int j = 0; j < 8; j++) begin
        dd[j] = 8'($urandom);
        ll[j] = (j == n - 1);
      end
      for (int j = 0; j < 4; j++) md[j] = dd[j];
      sbq.push_back(model(md, n, 1'b1));
      send(dd, ll, n, xf);
      wait_done();
      chk("rand_latency", 128'(rise_cyc - xf), 128'd1);
    end

    chk("scoreboard_empty", 128'(sbq.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
